quick_cpu_mem: RTL and testbench

Byte-wide memory responder for the quick CPU's memory bus. It sits on the far side of the CPU's address/data output byte and its read and write strobes, and returns read data on the byte the CPU samples as `ui_in`. It commits stores using the CPU's two-cycle address-then-data write sequence. A host-side programming port preloads program and data bytes while the CPU is held in reset.

---
 rtl/quick_cpu_mem.sv | 167 ++++++++++++++++
 tb/tb_quick_cpu_mem.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/quick_cpu_mem.sv
// quick_cpu_mem
// Byte-wide memory responder for the quick CPU's memory bus.
// The CPU reads data with zero latency. It stores with a two-cycle sequence:
// the address comes with mem_write, and the data follows in the next cycle.
// A host programming port can preload bytes while the CPU is held in reset.
//
// Optional feature macro: QUICK_MEM_PROG_EN
//   defined   -> programming port active
//   undefined -> prog_* inputs ignored, prog_ptr tied to 0, bus always served
//
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset (clears array, FSM, flags)
//   bus_ab     : CPU output byte (address in strobe cycles, data after mem_write)
//   mem_read   : CPU read strobe
//   mem_write  : CPU write strobe (bus_ab carries the address this cycle)
//   rd_data    : combinational read data returned to the CPU
//   wr_done    : one-cycle pulse after any array write commits
//   err        : sticky protocol-error flag, cleared only by reset
//   prog_en    : programming mode, CPU strobes ignored while high
//   prog_valid : write prog_data at prog_ptr this cycle
//   prog_data  : programming byte
//   prog_ptr   : current programming pointer

module quick_cpu_mem #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        bus_ab,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [7:0]        rd_data,
  output logic              wr_done,
  output logic              err,
  input  logic              prog_en,
  input  logic              prog_valid,
  input  logic [7:0]        prog_data,
  output logic [ADDR_W-1:0] prog_ptr
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    WDATA = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        mem [DEPTH];

  // Only the low address bits are decoded; upper bits alias.
  logic [ADDR_W-1:0] bus_idx;
  assign bus_idx = bus_ab[ADDR_W-1:0];

  logic              prog_active;
  logic              prog_wr;
  logic [ADDR_W-1:0] prog_wr_idx;
  logic [7:0]        prog_wr_data;

`ifdef QUICK_MEM_PROG_EN
  logic [ADDR_W-1:0] prog_ptr_q;

  assign prog_active  = prog_en;
  assign prog_wr      = prog_en & prog_valid;
  assign prog_wr_idx  = prog_ptr_q;
  assign prog_wr_data = prog_data;
  assign prog_ptr     = prog_ptr_q;

  // The pointer only advances while programming and snaps back to 0 as soon
  // as prog_en drops, so every programming session starts at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_ptr_q <= '0;
    end else if (!prog_en) begin
      prog_ptr_q <= '0;
    end else if (prog_valid) begin
      prog_ptr_q <= prog_ptr_q + ADDR_W'(1);
    end
  end
`else
  logic prog_unused;

  assign prog_active  = 1'b0;
  assign prog_wr      = 1'b0;
  assign prog_wr_idx  = '0;
  assign prog_wr_data = 8'h00;
  assign prog_ptr     = '0;
  assign prog_unused  = ^{prog_en, prog_valid, prog_data};
`endif

  logic latch_addr;
  logic bus_commit;
  logic err_set;
  logic rd_en;

  // Write FSM decode. When programming is active, the CPU side is masked:
  // no reads, no address latch, no error reports, and a pending store is dropped.
  always_comb begin
    state_nxt  = state;
    latch_addr = 1'b0;
    bus_commit = 1'b0;
    err_set    = 1'b0;
    rd_en      = 1'b0;
    case (state)
      IDLE: begin
        if (!prog_active) begin
          if (mem_read) begin
            // A simultaneous write strobe is flagged; the cycle is still a read.
            rd_en   = 1'b1;
            err_set = mem_write;
          end else if (mem_write) begin
            latch_addr = 1'b1;
            state_nxt  = WDATA;
          end
        end
      end
      WDATA: begin
        state_nxt = IDLE;
        if (!prog_active) begin
          bus_commit = 1'b1;
          err_set    = mem_read | mem_write;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus and programming writes cannot overlap because bus_commit is gated by !prog_active.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_widx;
  logic [7:0]        mem_wdata;

  assign mem_we    = bus_commit | prog_wr;
  assign mem_widx  = bus_commit ? waddr  : prog_wr_idx;
  assign mem_wdata = bus_commit ? bus_ab : prog_wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      waddr   <= '0;
      wr_done <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_done <= mem_we;
      err     <= err | err_set;
      if (latch_addr) begin
        waddr <= bus_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  assign rd_data = rd_en ? mem[bus_idx] : 8'h00;

endmodule

// File: tb/tb_quick_cpu_mem.sv
// tb_quick_cpu_mem
// Directed testbench for quick_cpu_mem (default ADDR_W = 5).
// Inputs change 1 time unit after each rising edge. Outputs are sampled at the
// following falling edge, so combinational rd_data reflects the current inputs
// and registered outputs reflect the previous edge.
// The programming-port section follows QUICK_MEM_PROG_EN.

module tb_quick_cpu_mem;

  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic [7:0]        bus_ab;
  logic              mem_read;
  logic              mem_write;
  logic [7:0]        rd_data;
  logic              wr_done;
  logic              err;
  logic              prog_en;
  logic              prog_valid;
  logic [7:0]        prog_data;
  logic [ADDR_W-1:0] prog_ptr;

  int tests_run;
  int tests_failed;

  quick_cpu_mem #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_ab    (bus_ab),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .rd_data   (rd_data),
    .wr_done   (wr_done),
    .err       (err),
    .prog_en   (prog_en),
    .prog_valid(prog_valid),
    .prog_data (prog_data),
    .prog_ptr  (prog_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then wait until the falling edge to sample.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] bus,
                               input logic pen, input logic pval, input logic [7:0] pdata);
    @(posedge clk);
    #1;
    mem_read   = rd;
    mem_write  = wr;
    bus_ab     = bus;
    prog_en    = pen;
    prog_valid = pval;
    prog_data  = pdata;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n      = 1'b0;
    bus_ab     = 8'h00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    prog_en    = 1'b0;
    prog_valid = 1'b0;
    prog_data  = 8'h00;

    // Reset state
    #2;
    checkOutput("reset rd_data", rd_data, 8'h00);
    checkOutput("reset wr_done", wr_done, 1'b0);
    checkOutput("reset err", err, 1'b0);
    checkOutput("reset prog_ptr", prog_ptr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bus store 0xA5 to 0x04, then read it back
    applyStimulus(1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 8'h00);
    checkOutput("store addr wr_done", wr_done, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00);
    checkOutput("store data wr_done", wr_done, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 8'h00);
    checkOutput("store readback", rd_data, 8'hA5);
    checkOutput("store wr_done pulse", wr_done, 1'b1);
    checkOutput("store err", err, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 8'h00);
    checkOutput("no strobe rd_data", rd_data, 8'h00);
    checkOutput("wr_done single", wr_done, 1'b0);

    // Aliasing: 0x27 and 0x07 are the same index
    applyStimulus(1'b0, 1'b1, 8'h27, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h5C, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 8'h00);
    checkOutput("alias read 0x07", rd_data, 8'h5C);
    applyStimulus(1'b1, 1'b0, 8'hE7, 1'b0, 1'b0, 8'h00);
    checkOutput("alias read 0xE7", rd_data, 8'h5C);
    applyStimulus(1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 8'h00);
    checkOutput("unwritten read", rd_data, 8'h00);

`ifdef QUICK_MEM_PROG_EN
    // Program 0x11, 0x22, 0x33 from index 0; reads are masked while programming
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11);
    checkOutput("prog ptr 0", prog_ptr, 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22);
    checkOutput("prog ptr 1", prog_ptr, 1);
    applyStimulus(1'b1, 1'b0, 8'h04, 1'b1, 1'b1, 8'h33);
    checkOutput("prog ptr 2", prog_ptr, 2);
    checkOutput("read masked in prog", rd_data, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 8'h00);
    checkOutput("prog readback 0x01", rd_data, 8'h22);
    checkOutput("prog ptr 3", prog_ptr, 3);
    checkOutput("prog wr_done", wr_done, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 8'h00);
    checkOutput("prog readback 0x02", rd_data, 8'h33);
    checkOutput("prog ptr cleared", prog_ptr, 0);

    // Raising prog_en in the data cycle aborts the pending store
    applyStimulus(1'b0, 1'b1, 8'h08, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h08, 1'b0, 1'b0, 8'h00);
    checkOutput("abort no write", rd_data, 8'h00);
    checkOutput("abort wr_done", wr_done, 1'b0);
    checkOutput("abort err", err, 1'b0);

    // 33 bytes: the last one wraps onto index 0
    for (int k = 0; k < 33; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h80 + 8'(k));
    end
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("wrap prog_ptr", prog_ptr, 1);
    checkOutput("wrap index 0", rd_data, 8'hA0);
    applyStimulus(1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 8'h00);
    checkOutput("wrap index 1", rd_data, 8'h81);
    applyStimulus(1'b1, 1'b0, 8'h1F, 1'b0, 1'b0, 8'h00);
    checkOutput("wrap index 31", rd_data, 8'h9F);
`else
    // Programming port compiled out: prog inputs do nothing, bus always served
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h77);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h77);
    checkOutput("macro off prog_ptr", prog_ptr, 0);
    checkOutput("macro off wr_done", wr_done, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h77);
    checkOutput("macro off index 0", rd_data, 8'h00);
    checkOutput("macro off wr_done 2", wr_done, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h04, 1'b1, 1'b0, 8'h00);
    checkOutput("macro off bus served", rd_data, 8'hA5);
    applyStimulus(1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 8'h00);
    checkOutput("macro off index 1", rd_data, 8'h00);
    checkOutput("macro off prog_ptr 2", prog_ptr, 0);
`endif

    // Reset during the data cycle drops the store and clears the array
    applyStimulus(1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    bus_ab    = 8'hFF;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset mid wr_done", wr_done, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 8'h00);
    checkOutput("reset mid read 0x02", rd_data, 8'h00);
    checkOutput("reset mid wr_done 2", wr_done, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 8'h00);
    checkOutput("reset cleared 0x04", rd_data, 8'h00);

    // Read and write together: treated as a read, err set and held
    applyStimulus(1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00);
    checkOutput("rw conflict read", rd_data, 8'h3C);
    checkOutput("rw conflict err pre", err, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'hEE, 1'b0, 1'b0, 8'h00);
    checkOutput("rw conflict err", err, 1'b1);
    checkOutput("rw conflict wr_done", wr_done, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 8'h00);
    checkOutput("rw conflict no write", rd_data, 8'h3C);
    checkOutput("err sticky", err, 1'b1);

    // Reset clears err; then a read during the data cycle
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    mem_read = 1'b0;
    #2;
    checkOutput("err cleared by reset", err, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h06, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 8'h00);
    checkOutput("read in WDATA rd_data", rd_data, 8'h00);
    checkOutput("read in WDATA err pre", err, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h06, 1'b0, 1'b0, 8'h00);
    checkOutput("WDATA store commits", rd_data, 8'h66);
    checkOutput("WDATA err set", err, 1'b1);
    checkOutput("WDATA wr_done", wr_done, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
